if_fetch_unit: RTL and testbench

//  Instruction-fetch stage: owns the PC and fetches 32-bit words over a Wishbone classic master port.

---
 rtl/fetch_pkg.sv | 16 +
 rtl/if_fetch_unit_if.sv | 23 ++
 rtl/fetch_hold_buf.sv | 42 ++++
 rtl/if_fetch_unit.sv | 203 ++++++++++++++++++++
 tb/tb_if_fetch_unit.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  typedef enum logic [2:0] {
    S_RST   = 3'd0,
    S_REQ   = 3'd1,
    S_HOLD  = 3'd2,
    S_DROP  = 3'd3,
    S_FAULT = 3'd4
  } fetch_state_e;

  localparam logic [31:0] NOP_INST   = 32'h0000_0013;
  localparam int unsigned PC_STEP    = 4;
  localparam logic [3:0]  WB_SEL_ALL = 4'hF;

endpackage

// File: rtl/if_fetch_unit_if.sv
// Wishbone classic read port between the fetch stage (master) and instruction memory (slave).
interface if_fetch_unit_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  wb_cyc_o;
  logic                  wb_stb_o;
  logic                  wb_we_o;
  logic [3:0]            wb_sel_o;
  logic [ADDR_WIDTH-1:0] wb_adr_o;
  logic [DATA_WIDTH-1:0] wb_dat_i;
  logic                  wb_ack_i;

  modport master (
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o,
    input  wb_dat_i, wb_ack_i
  );

  modport slave (
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o,
    output wb_dat_i, wb_ack_i
  );
endinterface

// File: rtl/fetch_hold_buf.sv
// One-entry {pc,inst} skid buffer: catches a fetched word while decode is stalled.
module fetch_hold_buf #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_load,
  input  logic                  i_drain,
  input  logic                  i_clear,
  input  logic [ADDR_WIDTH-1:0] i_pc,
  input  logic [DATA_WIDTH-1:0] i_inst,
  output logic                  o_valid,
  output logic [ADDR_WIDTH-1:0] o_pc,
  output logic [DATA_WIDTH-1:0] o_inst
);

  logic                  r_valid;
  logic [ADDR_WIDTH-1:0] r_pc;
  logic [DATA_WIDTH-1:0] r_inst;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_pc    <= '0;
      r_inst  <= '0;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_pc    <= i_pc;
      r_inst  <= i_inst;
    end else if (i_drain) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_pc    = r_pc;
  assign o_inst  = r_inst;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: PC, Wishbone fetch FSM, redirect handling and IF/ID register.
// Optional FETCH_MISALIGN_CHECK_EN: misaligned redirect targets raise if_fault instead of fetching.
module if_fetch_unit
  import fetch_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] PC_ADDR    = 32'h8000_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  use_branch,
  input  logic [ADDR_WIDTH-1:0] branch_out,
  input  logic                  flush,
  input  logic                  id_stall,
  if_fetch_unit_if.master       wb,
  output logic                  if_valid,
  output logic [ADDR_WIDTH-1:0] if_pc,
  output logic [DATA_WIDTH-1:0] if_inst,
  output logic                  if_fault
);

  localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(PC_STEP);
  localparam logic [DATA_WIDTH-1:0] NOP  = DATA_WIDTH'(NOP_INST);

  fetch_state_e          r_state;
  logic                  r_cyc;
  logic                  r_redir_pend;
  logic [ADDR_WIDTH-1:0] r_pc;
  logic [ADDR_WIDTH-1:0] r_redir_tgt;
  logic                  r_if_valid;
  logic                  r_if_fault;
  logic [ADDR_WIDTH-1:0] r_if_pc;
  logic [DATA_WIDTH-1:0] r_if_inst;

  logic                  w_ack;
  logic                  w_take;
  logic                  w_go_fault;
  logic [ADDR_WIDTH-1:0] w_tgt;
  logic [ADDR_WIDTH-1:0] w_go_tgt;
  logic [ADDR_WIDTH-1:0] w_pc_next;
  logic                  w_buf_load;
  logic                  w_buf_drain;
  logic                  w_buf_clear;
  logic                  w_buf_valid;
  logic [ADDR_WIDTH-1:0] w_buf_pc;
  logic [DATA_WIDTH-1:0] w_buf_inst;

  // Acks outside an active cycle (e.g. stale ones after reset) are ignored.
  assign w_ack     = wb.wb_ack_i && r_cyc;
  assign w_pc_next = r_pc + STEP;

`ifdef FETCH_MISALIGN_CHECK_EN
  assign w_tgt      = branch_out;
  assign w_go_tgt   = use_branch ? w_tgt : r_redir_tgt;
  assign w_go_fault = |w_go_tgt[1:0];
`else
  assign w_tgt      = branch_out & ~ADDR_WIDTH'(3);
  assign w_go_tgt   = use_branch ? w_tgt : r_redir_tgt;
  assign w_go_fault = 1'b0;
`endif

  // Cycles in which the PC jumps to a redirect target (live or latched).
  always_comb begin
    w_take = 1'b0;
    case (r_state)
      S_REQ:   w_take = use_branch && w_ack;
      S_HOLD:  w_take = use_branch;
      S_DROP:  w_take = w_ack && r_redir_pend;
      S_FAULT: w_take = use_branch;
      default: w_take = 1'b0;
    endcase
  end

  assign w_buf_load  = (r_state == S_REQ) && w_ack && !use_branch && id_stall;
  assign w_buf_drain = (r_state == S_HOLD) && !use_branch && !id_stall;
  assign w_buf_clear = (r_state == S_HOLD) && use_branch;

  fetch_hold_buf #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_hold_buf (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_buf_load),
    .i_drain (w_buf_drain),
    .i_clear (w_buf_clear),
    .i_pc    (r_pc),
    .i_inst  (wb.wb_dat_i),
    .o_valid (w_buf_valid),
    .o_pc    (w_buf_pc),
    .o_inst  (w_buf_inst)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_RST;
      r_cyc        <= 1'b0;
      r_redir_pend <= 1'b0;
      r_redir_tgt  <= '0;
      r_pc         <= PC_ADDR;
      r_if_valid   <= 1'b0;
      r_if_fault   <= 1'b0;
      r_if_pc      <= PC_ADDR;
      r_if_inst    <= NOP;
    end else begin
      // Decode consumes the IF/ID word whenever it is not stalling.
      if (!id_stall && r_state != S_FAULT) begin
        r_if_valid <= 1'b0;
      end

      if (w_take) begin
        r_redir_pend <= 1'b0;
        r_pc         <= w_go_tgt;
        r_if_fault   <= 1'b0;
        if (w_go_fault) begin
          r_state    <= S_FAULT;
          r_cyc      <= 1'b0;
          r_if_valid <= 1'b1;
          r_if_fault <= 1'b1;
          r_if_pc    <= w_go_tgt;
          r_if_inst  <= NOP;
        end else begin
          r_state <= S_REQ;
          r_cyc   <= 1'b1;
          if (r_state == S_FAULT) begin
            r_if_valid <= 1'b0;
          end
        end
      end else begin
        unique case (r_state)
          S_RST: begin
            r_state <= S_REQ;
            r_cyc   <= 1'b1;
          end
          S_REQ: begin
            if (use_branch) begin
              // The in-flight cycle must complete; its data is dropped later.
              r_redir_tgt  <= w_tgt;
              r_redir_pend <= 1'b1;
              r_state      <= S_DROP;
            end else if (w_ack) begin
              if (id_stall) begin
                r_state <= S_HOLD;
                r_cyc   <= 1'b0;
              end else begin
                if (!flush) begin
                  r_if_valid <= 1'b1;
                  r_if_pc    <= r_pc;
                  r_if_inst  <= wb.wb_dat_i;
                end
                r_pc <= w_pc_next;
              end
            end
          end
          S_HOLD: begin
            if (!id_stall) begin
              if (w_buf_valid && !flush) begin
                r_if_valid <= 1'b1;
                r_if_pc    <= w_buf_pc;
                r_if_inst  <= w_buf_inst;
              end
              r_pc    <= w_pc_next;
              r_state <= S_REQ;
              r_cyc   <= 1'b1;
            end
          end
          S_DROP: begin
            if (use_branch) begin
              r_redir_tgt <= w_tgt;
            end
          end
`ifdef FETCH_MISALIGN_CHECK_EN
          S_FAULT: begin
            r_state <= S_FAULT;
          end
`endif
          default: begin
            r_state <= S_RST;
            r_cyc   <= 1'b0;
          end
        endcase
      end

      if (flush) begin
        r_if_valid <= 1'b0;
        r_if_fault <= 1'b0;
      end
    end
  end

  assign wb.wb_cyc_o = r_cyc;
  assign wb.wb_stb_o = r_cyc;
  assign wb.wb_we_o  = 1'b0;
  assign wb.wb_sel_o = WB_SEL_ALL;
  assign wb.wb_adr_o = r_pc;

  assign if_valid = r_if_valid;
  assign if_pc    = r_if_pc;
  assign if_inst  = r_if_inst;
  assign if_fault = r_if_fault;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed scenarios followed by randomized traffic checked against an instruction-stream model.
module tb_if_fetch_unit;
  import fetch_pkg::*;

  localparam logic [31:0] PC0 = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        use_branch;
  logic [31:0] branch_out;
  logic        flush;
  logic        id_stall;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_fault;

  int n_tests = 0;
  int n_fail  = 0;

  if_fetch_unit_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) wb ();

  if_fetch_unit #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .PC_ADDR    (PC0)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .use_branch (use_branch),
    .branch_out (branch_out),
    .flush      (flush),
    .id_stall   (id_stall),
    .wb         (wb.master),
    .if_valid   (if_valid),
    .if_pc      (if_pc),
    .if_inst    (if_inst),
    .if_fault   (if_fault)
  );

  always #5 clk = ~clk;

  // Instruction memory contents as a pure function of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic ack_word();
    wb.wb_ack_i = 1'b1;
    wb.wb_dat_i = mem_word(wb.wb_adr_o);
  endtask

  task automatic clr_inputs();
    wb.wb_ack_i = 1'b0;
    use_branch  = 1'b0;
    flush       = 1'b0;
    branch_out  = '0;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    id_stall = 1'b0;
    wb.wb_dat_i = '0;
    clr_inputs();
    tick();
    tick();
  endtask

  logic [31:0] exp_pc;
  logic [31:0] tgt;
  logic        prev_cyc, prev_ack, prev_stall, prev_flush;
  logic [31:0] prev_adr, prev_pc, prev_inst;
  logic        prev_valid;
  int          n_accept;

  initial begin
    // ---- reset state ----
    do_reset();
    check_eq("rst_cyc",   wb.wb_cyc_o, 0);
    check_eq("rst_valid", if_valid, 0);
    check_eq("rst_pc",    if_pc, PC0);
    check_eq("rst_inst",  if_inst, 32'h0000_0013);
    check_eq("rst_fault", if_fault, 0);
    reset = 1'b0;
    tick();
    check_eq("t1_cyc", wb.wb_cyc_o, 1);

    // ---- 1: ack every 2nd cycle ----
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("t1_adr", wb.wb_adr_o, PC0 + 32'(4 * i));
      ack_word();
      tick();
      wb.wb_ack_i = 1'b0;
      check_eq("t1_valid", if_valid, 1);
      check_eq("t1_pc",    if_pc, PC0 + 32'(4 * i));
      check_eq("t1_inst",  if_inst, mem_word(PC0 + 32'(4 * i)));
    end

    // ---- 2: ack under a 3-cycle stall ----
    id_stall = 1'b1;
    ack_word();
    tick();
    wb.wb_ack_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_eq("t2_cyc_low", wb.wb_cyc_o, 0);
      check_eq("t2_hold_pc", {if_valid, if_pc}, {1'b1, PC0 + 32'h8});
      if (i < 2) tick();
    end
    id_stall = 1'b0;
    tick();
    check_eq("t2_drain", {if_valid, if_pc, if_inst}, {1'b1, PC0 + 32'hC, mem_word(PC0 + 32'hC)});
    check_eq("t2_next_adr", {wb.wb_cyc_o, wb.wb_adr_o}, {1'b1, PC0 + 32'h10});

    // ---- 3: redirect while ack pending ----
    use_branch = 1'b1; flush = 1'b1; branch_out = PC0 + 32'h100;
    tick();
    clr_inputs();
    check_eq("t3_keep_adr", {wb.wb_cyc_o, wb.wb_adr_o, if_valid}, {1'b1, PC0 + 32'h10, 1'b0});
    tick();
    ack_word();
    tick();
    wb.wb_ack_i = 1'b0;
    check_eq("t3_drop", {if_valid, wb.wb_adr_o}, {1'b0, PC0 + 32'h100});
    ack_word();
    tick();
    wb.wb_ack_i = 1'b0;
    check_eq("t3_target", {if_valid, if_pc}, {1'b1, PC0 + 32'h100});

    // ---- 4: two redirects in one drop ----
    use_branch = 1'b1; flush = 1'b1; branch_out = PC0 + 32'h100;
    tick();
    branch_out = PC0 + 32'h200;
    tick();
    clr_inputs();
    ack_word();
    tick();
    wb.wb_ack_i = 1'b0;
    check_eq("t4_newest", {if_valid, wb.wb_adr_o}, {1'b0, PC0 + 32'h200});
    ack_word();
    tick();
    wb.wb_ack_i = 1'b0;
    check_eq("t4_target", {if_valid, if_pc}, {1'b1, PC0 + 32'h200});

    // ---- 5: flush under stall; redirect with same-cycle ack ----
    id_stall = 1'b1; flush = 1'b1;
    tick();
    flush = 1'b0; id_stall = 1'b0;
    check_eq("t5_flush", if_valid, 0);
    use_branch = 1'b1; flush = 1'b1; branch_out = PC0 + 32'h300;
    ack_word();
    tick();
    clr_inputs();
    check_eq("t5_redir_ack", {if_valid, wb.wb_adr_o}, {1'b0, PC0 + 32'h300});
    ack_word();
    tick();
    wb.wb_ack_i = 1'b0;
    check_eq("t5_target", {if_valid, if_pc}, {1'b1, PC0 + 32'h300});

    // ---- 6: misaligned redirect target ----
    use_branch = 1'b1; flush = 1'b1; branch_out = PC0 + 32'h102;
    tick();
    clr_inputs();
    ack_word();
    tick();
    wb.wb_ack_i = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
    check_eq("t6_fault", {wb.wb_cyc_o, if_valid, if_fault, if_pc, if_inst},
             {1'b0, 1'b1, 1'b1, PC0 + 32'h102, 32'h0000_0013});
`else
    check_eq("t6_align", {wb.wb_cyc_o, wb.wb_adr_o, if_fault}, {1'b1, PC0 + 32'h100, 1'b0});
`endif

    // ---- randomized traffic against the instruction-stream model ----
    do_reset();
    reset = 1'b0;
    tick();
    exp_pc     = PC0;
    n_accept   = 0;
    prev_cyc   = 1'b0;
    prev_ack   = 1'b0;
    prev_stall = 1'b0;
    prev_flush = 1'b0;
    prev_adr   = '0;
    prev_valid = 1'b0;
    prev_pc    = '0;
    prev_inst  = '0;
    for (int c = 0; c < 4000; c++) begin
      check_eq("bus_static", {wb.wb_stb_o, wb.wb_we_o, wb.wb_sel_o}, {wb.wb_cyc_o, 1'b0, 4'hF});
      if (prev_cyc && !prev_ack)
        check_eq("bus_hold", {wb.wb_cyc_o, wb.wb_adr_o}, {1'b1, prev_adr});
      if (prev_stall && !prev_flush)
        check_eq("if_hold", {if_valid, if_pc, if_inst}, {prev_valid, prev_pc, prev_inst});

      id_stall   = ($urandom % 4) == 0;
      use_branch = ($urandom % 20) == 0;
      flush      = use_branch;
      if (($urandom % 4) == 0) tgt = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      else                     tgt = PC0 + 32'($urandom_range(0, 4095));
`ifdef FETCH_MISALIGN_CHECK_EN
      tgt[1:0] = 2'b00;
`endif
      branch_out  = tgt;
      wb.wb_ack_i = wb.wb_cyc_o && ($urandom % 2 == 0);
      wb.wb_dat_i = mem_word(wb.wb_adr_o);

      if (if_valid && !id_stall && !flush) begin
        check_eq("seq_pc",   if_pc, exp_pc);
        check_eq("seq_inst", if_inst, mem_word(exp_pc));
        exp_pc = exp_pc + 32'd4;
        n_accept++;
      end
      if (use_branch) exp_pc = tgt & ~32'd3;

      prev_cyc   = wb.wb_cyc_o;
      prev_ack   = wb.wb_ack_i;
      prev_adr   = wb.wb_adr_o;
      prev_stall = id_stall;
      prev_flush = flush;
      prev_valid = if_valid;
      prev_pc    = if_pc;
      prev_inst  = if_inst;
      tick();
    end
    check_eq("liveness", (n_accept > 200), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
